// File: rtl/move_sync.sv
`default_nettype none
// ============================================================================
//  Module      : move_sync
//  Description : Two-player move synchroniser. Collects one move per player
//                per round (rising-edge press detection, fixed priority),
//                forces "wait" for a missing move after TIMEOUT cycles,
//                issues both moves as single-cycle registered strobes, then
//                holds off new collection for GAP cooldown cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module move_sync #(
   parameter int TIMEOUT = 8,   // COLLECT cycles before empty slots become wait (>= 1)
   parameter int GAP     = 2    // cooldown cycles after each issued round (>= 1)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       game_over,
   input  logic [5:0] btn1,
   input  logic [5:0] btn2,
   output logic       punch1,
   output logic       kick1,
   output logic       wait1,
   output logic       jump1,
   output logic       left1,
   output logic       right1,
   output logic       punch2,
   output logic       kick2,
   output logic       wait2,
   output logic       jump2,
   output logic       left2,
   output logic       right2,
   output logic       round_valid,
   output logic       busy,
   output logic [7:0] round_cnt
);

   // Move codes equal the button bit index: {right,left,jump,wait,kick,punch}
   localparam logic [2:0] c_mv_wait = 3'd2;

   localparam logic [1:0] c_st_idle     = 2'd0;
   localparam logic [1:0] c_st_collect  = 2'd1;
   localparam logic [1:0] c_st_issue    = 2'd2;
   localparam logic [1:0] c_st_cooldown = 2'd3;

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [TW-1:0] c_timer_last = TW'(TIMEOUT - 1);
   localparam logic [GW-1:0] c_gap_last   = GW'(GAP - 1);

   logic [1:0]    r_state;
   logic [1:0]    w_state_n;
   logic [5:0]    r_btn1_q;
   logic [5:0]    r_btn2_q;
   logic [5:0]    w_press1;
   logic [5:0]    w_press2;
   logic          r_v1;
   logic          r_v2;
   logic [2:0]    r_m1;
   logic [2:0]    r_m2;
   logic          w_v1_n;
   logic          w_v2_n;
   logic [2:0]    w_m1_n;
   logic [2:0]    w_m2_n;
   logic [TW-1:0] r_timer;
   logic [GW-1:0] r_gap;
   logic          w_timeout;
   logic          w_stop;
   logic [5:0]    r_str1;
   logic [5:0]    r_str2;
   logic [5:0]    w_str1_n;
   logic [5:0]    w_str2_n;
   logic          r_round_valid;
   logic          w_round_valid_n;
   logic [7:0]    r_round_cnt;

   // Priority punch > kick > jump > left > right > wait; caller gates on |p
   function automatic logic [2:0] f_pri(input logic [5:0] p);
      logic [2:0] v_code;
      v_code = c_mv_wait;
      if (p[0])      v_code = 3'd0;
      else if (p[1]) v_code = 3'd1;
      else if (p[3]) v_code = 3'd3;
      else if (p[4]) v_code = 3'd4;
      else if (p[5]) v_code = 3'd5;
      return v_code;
   endfunction

   assign w_press1  = btn1 & ~r_btn1_q;
   assign w_press2  = btn2 & ~r_btn2_q;
   assign w_timeout = (r_timer == c_timer_last);
   assign w_stop    = !en || game_over;

   // Round state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= c_st_idle;
      else        r_state <= w_state_n;
   end

   // Next-state decision
   always_comb begin
      w_state_n = r_state;
      case (r_state)
         c_st_idle:     if (!w_stop) w_state_n = c_st_collect;
         c_st_collect: begin
            if (w_stop)                           w_state_n = c_st_idle;
            else if ((r_v1 && r_v2) || w_timeout) w_state_n = c_st_issue;
         end
         c_st_issue:    w_state_n = c_st_cooldown;
         c_st_cooldown: begin
            if (w_stop)                   w_state_n = c_st_idle;
            else if (r_gap == c_gap_last) w_state_n = c_st_collect;
         end
         default:       w_state_n = c_st_idle;
      endcase
   end

   // Slot update: clear on entry to IDLE/COLLECT, first press wins, timeout fills wait
   always_comb begin
      w_v1_n = r_v1;
      w_m1_n = r_m1;
      w_v2_n = r_v2;
      w_m2_n = r_m2;
      if (w_state_n == c_st_idle ||
          (w_state_n == c_st_collect && r_state != c_st_collect)) begin
         w_v1_n = 1'b0;
         w_m1_n = c_mv_wait;
         w_v2_n = 1'b0;
         w_m2_n = c_mv_wait;
      end else if (r_state == c_st_collect) begin
         // A press on the timeout cycle takes precedence over the forced wait
         if (!r_v1 && (|w_press1)) begin
            w_v1_n = 1'b1;
            w_m1_n = f_pri(w_press1);
         end else if (!r_v1 && w_timeout) begin
            w_v1_n = 1'b1;
            w_m1_n = c_mv_wait;
         end
         if (!r_v2 && (|w_press2)) begin
            w_v2_n = 1'b1;
            w_m2_n = f_pri(w_press2);
         end else if (!r_v2 && w_timeout) begin
            w_v2_n = 1'b1;
            w_m2_n = c_mv_wait;
         end
      end
   end

   // Output decode: strobes prepared one edge ahead so they are flop outputs in ISSUE
   always_comb begin
      w_str1_n        = '0;
      w_str2_n        = '0;
      w_round_valid_n = 1'b0;
      if (w_state_n == c_st_issue) begin
         w_str1_n        = 6'b000001 << w_m1_n;
         w_str2_n        = 6'b000001 << w_m2_n;
         w_round_valid_n = 1'b1;
      end
   end

   // Datapath registers: button history, slots, timers, strobes, round counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_btn1_q      <= '0;
         r_btn2_q      <= '0;
         r_v1          <= 1'b0;
         r_v2          <= 1'b0;
         r_m1          <= c_mv_wait;
         r_m2          <= c_mv_wait;
         r_timer       <= '0;
         r_gap         <= '0;
         r_str1        <= '0;
         r_str2        <= '0;
         r_round_valid <= 1'b0;
         r_round_cnt   <= '0;
      end else begin
         r_btn1_q      <= btn1;
         r_btn2_q      <= btn2;
         r_v1          <= w_v1_n;
         r_v2          <= w_v2_n;
         r_m1          <= w_m1_n;
         r_m2          <= w_m2_n;
         r_timer       <= (r_state == c_st_collect && w_state_n == c_st_collect) ?
                          r_timer + TW'(1) : '0;
         r_gap         <= (r_state == c_st_cooldown && w_state_n == c_st_cooldown) ?
                          r_gap + GW'(1) : '0;
         r_str1        <= w_str1_n;
         r_str2        <= w_str2_n;
         r_round_valid <= w_round_valid_n;
         if (r_state == c_st_issue) r_round_cnt <= r_round_cnt + 8'd1;
      end
   end

   assign punch1      = r_str1[0];
   assign kick1       = r_str1[1];
   assign wait1       = r_str1[2];
   assign jump1       = r_str1[3];
   assign left1       = r_str1[4];
   assign right1      = r_str1[5];
   assign punch2      = r_str2[0];
   assign kick2       = r_str2[1];
   assign wait2       = r_str2[2];
   assign jump2       = r_str2[3];
   assign left2       = r_str2[4];
   assign right2      = r_str2[5];
   assign round_valid = r_round_valid;
   assign busy        = (r_state == c_st_issue) || (r_state == c_st_cooldown);
   assign round_cnt   = r_round_cnt;

endmodule
`default_nettype wire

// File: tb/tb_move_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_move_sync
//  Description : Self-checking bench for move_sync (TIMEOUT=8, GAP=2):
//                cycle table of inputs/expected outputs plus hand sequences
//                for counter wrap and reset during an issue cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_move_sync;

   localparam logic [5:0] P = 6'b000001;
   localparam logic [5:0] K = 6'b000010;
   localparam logic [5:0] W = 6'b000100;
   localparam logic [5:0] J = 6'b001000;
   localparam logic [5:0] L = 6'b010000;
   localparam logic [5:0] R = 6'b100000;

   typedef struct {
      logic       en;
      logic       go;
      logic [5:0] b1;
      logic [5:0] b2;
      logic [5:0] s1;
      logic [5:0] s2;
      logic       rv;
      logic       bz;
      logic [7:0] cnt;
   } vec_t;

   logic       clk;
   logic       reset;
   logic       en;
   logic       game_over;
   logic [5:0] btn1;
   logic [5:0] btn2;
   logic       punch1, kick1, wait1, jump1, left1, right1;
   logic       punch2, kick2, wait2, jump2, left2, right2;
   logic       round_valid;
   logic       busy;
   logic [7:0] round_cnt;

   logic [5:0] s1;
   logic [5:0] s2;
   vec_t       vq[$];
   int         n_vec;
   int         n_err;
   logic [7:0] exp_cnt;

   assign s1 = {right1, left1, jump1, wait1, kick1, punch1};
   assign s2 = {right2, left2, jump2, wait2, kick2, punch2};

   move_sync #(.TIMEOUT(8), .GAP(2)) dut (
      .clk(clk), .reset(reset), .en(en), .game_over(game_over),
      .btn1(btn1), .btn2(btn2),
      .punch1(punch1), .kick1(kick1), .wait1(wait1),
      .jump1(jump1), .left1(left1), .right1(right1),
      .punch2(punch2), .kick2(kick2), .wait2(wait2),
      .jump2(jump2), .left2(left2), .right2(right2),
      .round_valid(round_valid), .busy(busy), .round_cnt(round_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic e, input logic g, input logic [5:0] b1, input logic [5:0] b2,
                      input logic [5:0] x1, input logic [5:0] x2, input logic rv,
                      input logic bz, input logic [7:0] c);
      vec_t v;
      v.en = e; v.go = g; v.b1 = b1; v.b2 = b2;
      v.s1 = x1; v.s2 = x2; v.rv = rv; v.bz = bz; v.cnt = c;
      vq.push_back(v);
   endtask

   // One complete round from COLLECT: punch vs kick, then 2 cooldown cycles
   task automatic do_round(input int idx);
      btn1 = P; btn2 = K; tick();
      btn1 = 0; btn2 = 0; tick();
      chk($sformatf("round%0d issue", idx), {18'd0, s1, s2, round_valid}, {18'd0, P, K, 1'b1});
      tick();
      exp_cnt = exp_cnt + 8'd1;
      chk($sformatf("round%0d cnt", idx), {24'd0, round_cnt}, {24'd0, exp_cnt});
      tick();
      tick();
   endtask

   initial begin
      clk = 0; reset = 0; en = 0; game_over = 0; btn1 = 0; btn2 = 0;
      n_vec = 0; n_err = 0;

      // Cycle table: inputs applied before an edge, outputs checked just after it
      add(1,0, 0, 0,     0, 0, 0,0,8'd0);   // IDLE -> COLLECT
      add(1,0, P, J,     0, 0, 0,0,8'd0);   // both captured
      add(1,0, P, J,     P, J, 1,1,8'd0);   // ISSUE
      add(1,0, 0, 0,     0, 0, 0,1,8'd1);   // COOLDOWN 1
      add(1,0, 0, 0,     0, 0, 0,1,8'd1);   // COOLDOWN 2
      add(1,0, 0, 0,     0, 0, 0,0,8'd1);   // COLLECT
      add(1,0, P|K|L, W, 0, 0, 0,0,8'd1);   // multi-press -> punch
      add(1,0, P|K|L, W, P, W, 1,1,8'd1);
      add(1,0, P|K|L, 0, 0, 0, 0,1,8'd2);
      add(1,0, P|K|L, 0, 0, 0, 0,1,8'd2);
      add(1,0, P|K|L, 0, 0, 0, 0,0,8'd2);   // held buttons, no new press
      add(1,0, R, 0,     0, 0, 0,0,8'd2);   // only right, timer 0
      for (int i = 0; i < 6; i++) add(1,0, 0, 0, 0, 0, 0,0,8'd2);
      add(1,0, 0, 0,     R, W, 1,1,8'd2);   // timeout after 8 COLLECT cycles
      add(1,0, 0, 0,     0, 0, 0,1,8'd3);
      add(1,0, 0, K,     0, 0, 0,1,8'd3);   // press during COOLDOWN discarded
      add(1,0, 0, K,     0, 0, 0,0,8'd3);
      add(1,0, J, K,     0, 0, 0,0,8'd3);   // kick still held: no press
      for (int i = 0; i < 6; i++) add(1,0, 0, 0, 0, 0, 0,0,8'd3);
      add(1,0, 0, 0,     J, W, 1,1,8'd3);   // player 2 forced to wait
      add(1,0, 0, 0,     0, 0, 0,1,8'd4);
      add(1,0, 0, 0,     0, 0, 0,1,8'd4);
      add(1,0, 0, 0,     0, 0, 0,0,8'd4);
      for (int i = 0; i < 7; i++) add(1,0, 0, 0, 0, 0, 0,0,8'd4);
      add(1,0, 0, L,     W, L, 1,1,8'd4);   // press on timeout cycle beats forced wait
      add(1,0, 0, 0,     0, 0, 0,1,8'd5);
      add(1,0, 0, 0,     0, 0, 0,1,8'd5);
      add(1,0, 0, 0,     0, 0, 0,0,8'd5);
      add(1,0, P, 0,     0, 0, 0,0,8'd5);   // slot 1 filled
      add(1,1, 0, 0,     0, 0, 0,0,8'd5);   // game_over mid-COLLECT -> IDLE
      add(1,1, 0, 0,     0, 0, 0,0,8'd5);
      add(1,0, 0, P,     0, 0, 0,0,8'd5);   // press in IDLE ignored
      add(1,0, 0, P,     0, 0, 0,0,8'd5);   // slot 1 must have been cleared
      add(1,0, 0, 0,     0, 0, 0,0,8'd5);

      #12;
      chk("reset state", {14'd0, s1, s2, round_valid, busy, round_cnt}, 32'd0);
      reset = 1;

      for (int i = 0; i < vq.size(); i++) begin
         en = vq[i].en; game_over = vq[i].go; btn1 = vq[i].b1; btn2 = vq[i].b2;
         tick();
         chk($sformatf("vec%0d", i),
             {10'd0, s1, s2, round_valid, busy, round_cnt},
             {10'd0, vq[i].s1, vq[i].s2, vq[i].rv, vq[i].bz, vq[i].cnt});
      end

      // Run rounds until the counter wraps past 255
      exp_cnt = 8'd5;
      for (int r = 0; r < 251; r++) do_round(r);
      chk("cnt wrap", {24'd0, round_cnt}, 32'd0);

      // Reset asserted inside the ISSUE cycle drops strobes without a clock edge
      btn1 = L; btn2 = R; tick();
      btn1 = 0; btn2 = 0; tick();
      chk("pre-reset issue", {19'd0, s1, s2, round_valid}, {19'd0, L, R, 1'b1});
      #2 reset = 0;
      #1;
      chk("async reset drop", {14'd0, s1, s2, round_valid, busy, round_cnt}, 32'd0);
      @(negedge clk);
      reset = 1;
      tick();
      chk("post-reset collect", {14'd0, s1, s2, round_valid, busy, round_cnt}, 32'd0);
      btn1 = P; btn2 = P; tick();
      btn1 = 0; btn2 = 0; tick();
      chk("post-reset issue", {10'd0, s1, s2, round_valid, busy, round_cnt},
          {10'd0, P, P, 1'b1, 1'b1, 8'd0});
      tick();
      chk("post-reset cnt", {24'd0, round_cnt}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/move_sync.md
MOVE_SYNC -- requirements
Module: move_sync

Interface
REQ-001 Parameter TIMEOUT, default 8, cycles in COLLECT before missing moves are forced to wait.
REQ-002 Parameter GAP, default 2, cooldown cycles after each issued round.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  round engine enable.
REQ-006 game_over  input  1  level; high freezes round issue.
REQ-007 btn1  input  6  player-1 raw buttons, bit order {right,left,jump,wait,kick,punch} (bit0=punch).
REQ-008 btn2  input  6  player-2 raw buttons, same order.
REQ-009 punch1,kick1,wait1,jump1,left1,right1  output  1 each  player-1 move strobes to the game core.
REQ-010 punch2,kick2,wait2,jump2,left2,right2  output  1 each  player-2 move strobes.
REQ-011 round_valid  output  1  high in the issue cycle.
REQ-012 busy  output  1  high in ISSUE or COOLDOWN.
REQ-013 round_cnt  output  8  count of issued rounds.

Function
REQ-014 Press detection SHALL be rising-edge: press = btn & ~btn_q, btn_q registered every cycle.
REQ-015 States SHALL be IDLE, COLLECT, ISSUE, COOLDOWN; encoding free.
REQ-016 IDLE -> COLLECT when en=1 and game_over=0; slots cleared, timer=0.
REQ-017 In COLLECT each player has one slot (valid flag + 3-bit move); first press captured, later presses ignored until next round.
REQ-018 Multiple bits pressed in one cycle SHALL resolve by priority punch > kick > jump > left > right > wait.
REQ-019 Timer SHALL increment each COLLECT cycle; counts only in COLLECT.
REQ-020 COLLECT -> ISSUE at the edge after both slots valid; slot capture and completion check in same cycle allowed (capture at edge k, ISSUE from edge k+1).
REQ-021 If timer reaches TIMEOUT-1 with a slot empty, empty slot(s) SHALL be filled with wait and state -> ISSUE at next edge.
REQ-022 A press arriving in the same cycle as timeout SHALL be captured in preference to the forced wait.
REQ-023 In ISSUE, exactly one strobe per player and round_valid SHALL be high for exactly one cycle; all strobes low in every other state.
REQ-024 round_cnt SHALL increment by 1 on leaving ISSUE, wrapping 255 -> 0.
REQ-025 ISSUE -> COOLDOWN; COOLDOWN lasts exactly GAP cycles, then COLLECT with slots cleared and timer=0.
REQ-026 Presses during ISSUE or COOLDOWN SHALL be discarded, not queued.
REQ-027 en=0 or game_over=1 sampled in COLLECT or COOLDOWN SHALL force IDLE at next edge, clearing slots; an ISSUE cycle in progress completes (strobes still issued once).
REQ-028 Strobes and round_valid SHALL be registered outputs, glitch-free.

Reset
REQ-029 reset=0 SHALL asynchronously force state IDLE, slots invalid, timer=0, btn_q=0, round_cnt=0.
REQ-030 During reset all strobes, round_valid and busy SHALL be 0.
REQ-031 Reset deassertion SHALL take effect at the next rising clk edge; first COLLECT no earlier than one edge after release.
REQ-032 Reset asserted mid-round SHALL drop any pending strobe in the same cycle, without waiting for clk.

Verification
REQ-033 btn1=punch, btn2=jump pressed same cycle in COLLECT -> punch1=1, jump2=1, round_valid=1 for one cycle, round_cnt 0->1.
REQ-034 Only btn1=right pressed, TIMEOUT=8 -> after 8 COLLECT cycles: right1=1, wait2=1 forced, one cycle.
REQ-035 btn1 = punch|kick|left same cycle -> only punch1 strobed; held button across rounds issues no second press.
REQ-036 Press during COOLDOWN (GAP=2) -> discarded; next round times out to wait unless re-pressed.
REQ-037 256 rounds -> round_cnt wraps to 0; game_over=1 mid-COLLECT -> IDLE, no strobe.
REQ-038 reset pulled low during ISSUE cycle -> strobes drop immediately, round_cnt=0, busy=0.
